// File: rtl/cmp_slice_seq_if.sv
// Request/result bundle for cmp_slice_seq: operands, opcode, valid/ready, enable, result and status.
interface cmp_slice_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [1:0]            OP;
  logic                  in_valid;
  logic                  in_ready;
  logic                  enable;
  logic [OUT_WIDTH-1:0]  CMP_out;
  logic                  CMP_flag;
  logic                  busy;

  modport master (
    output A, B, OP, in_valid, enable,
    input  in_ready, CMP_out, CMP_flag, busy
  );

  modport slave (
    input  A, B, OP, in_valid, enable,
    output in_ready, CMP_out, CMP_flag, busy
  );
endinterface

// File: rtl/cmp_slice_seq.sv
// Slice-serial magnitude comparator, MSB slice first with early exit on the first unequal slice.
// Latency: NOP result 1 cycle after accept; otherwise k slices (1..NUM_SLICES) plus enable-low stalls.
// Backpressure: in_ready only in IDLE, requests during RUN are ignored. CMP_SLICE_SIGNED_EN = signed operands.
module cmp_slice_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int SLICE_WIDTH = 4,
  parameter int OUT_WIDTH   = 2
) (
  input  logic          CLK,
  input  logic          RST,
  cmp_slice_seq_if.slave bus
);
  localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_SLICES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [OUT_WIDTH-1:0]  out_q, out_d;
  logic                  flag_q, flag_d;

  logic [SLICE_WIDTH-1:0] slice_a, slice_b;
  logic                   slice_gt, slice_lt;

  assign slice_a = a_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH];
  assign slice_b = b_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH];

  always_comb begin
    slice_gt = slice_a > slice_b;
    slice_lt = slice_a < slice_b;
`ifdef CMP_SLICE_SIGNED_EN
    // Only the top slice carries the sign; lower slices order as plain magnitudes.
    if (idx_q == IDX_TOP) begin
      slice_gt = $signed(slice_a) > $signed(slice_b);
      slice_lt = $signed(slice_a) < $signed(slice_b);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.OP == 2'b00) begin
            out_d  = '0;
            flag_d = 1'b1;
          end else begin
            state_d = RUN;
            a_d     = bus.A;
            b_d     = bus.B;
            op_d    = bus.OP;
            idx_d   = IDX_TOP;
          end
        end
      end
      RUN: begin
        if (bus.enable) begin
          if (slice_gt || slice_lt || idx_q == '0) begin
            state_d = IDLE;
            flag_d  = 1'b1;
            case (op_q)
              2'b01:   out_d = (!slice_gt && !slice_lt) ? OUT_WIDTH'(1) : '0;
              2'b10:   out_d = slice_gt ? OUT_WIDTH'(2) : '0;
              2'b11:   out_d = slice_lt ? OUT_WIDTH'(3) : '0;
              default: out_d = '0;
            endcase
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      idx_q   <= IDX_TOP;
      out_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q == RUN);
  assign bus.CMP_out  = out_q;
  assign bus.CMP_flag = flag_q;
endmodule
